multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
Moore/Mealy FSM that sequences the multicycle MIPS datapath and drives the ALU operation interface: alu_operation_o, alu_src_a_o and alu_src_b_o on the way in, zero_i on the way back. It decodes the IR opcode/funct fields into per-cycle datapath controls. It waits on a memory ready handshake and reports illegal instructions and memory timeouts. It sits beside the ALU and register file inside the MIPS top level.

Parameters:
MEM_TIMEOUT, 255, maximum cycles in any memory state waiting for mem_ready_i before abort (1..255).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
opcode_i  input  6  IR[31:26]
funct_i  input  6  IR[5:0]
zero_i  input  1  ALU zero flag, same cycle as alu_operation_o
mem_ready_i  input  1  memory completes the current access this cycle
ir_write_o  output  1  load IR
pc_write_o  output  1  load PC
i_or_d_o  output  1  memory address source: 0 PC, 1 ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
reg_write_o  output  1  register file write
reg_dst_o  output  2  write register: 00 rt, 01 rd, 10 $31
mem_to_reg_o  output  2  write data: 00 ALUOut, 01 MDR, 10 PC
alu_src_a_o  output  1  0 PC, 1 reg A
alu_src_b_o  output  2  00 reg B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2
zero_ext_o  output  1  1 zero-extend imm (ORI), 0 sign-extend
pc_src_o  output  2  00 ALU result, 01 ALUOut, 10 jump target
alu_operation_o  output  4  ADD 4'b0011, SUB 4'b0001, OR 4'b0010, LUI 4'b0100, SLL 4'b0101
illegal_o  output  1  one-cycle pulse on an unsupported opcode/funct
bus_error_o  output  1  one-cycle pulse on a memory timeout

Behaviour:
- Reset low (async): state=FETCH, wait counter=0. All outputs forced 0 while reset is low. First FETCH cycle follows reset release.
- States, 4-bit encoding: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Unlisted outputs are 0 in every state.
- FETCH: mem_read_o=1, i_or_d_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_operation_o=ADD, pc_src_o=00. ir_write_o and pc_write_o equal mem_ready_i. Stay in FETCH until mem_ready_i=1, then go to DECODE.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_operation_o=ADD (precomputes branch target). Next state by opcode:
  - 0x23 (LW) or 0x2B (SW) -> MEM_ADDR
  - 0x00 -> R_EXEC if funct is 0x20 ADD, 0x22 SUB, 0x25 OR or 0x00 SLL; any other funct is illegal
  - 0x08 (ADDI), 0x0D (ORI), 0x0F (LUI) -> I_EXEC
  - 0x04 (BEQ), 0x05 (BNE) -> BRANCH
  - 0x02 (J), 0x03 (JAL) -> JUMP
  - anything else: illegal_o=1 for this cycle, next state FETCH; PC is not rewound.
- MEM_ADDR: alu_src_a_o=1, alu_src_b_o=10, ADD. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read_o=1, i_or_d_o=1; hold until mem_ready_i=1, then MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=00, mem_to_reg_o=01. Next FETCH.
- MEM_WR: mem_write_o=1, i_or_d_o=1; hold until mem_ready_i=1, then FETCH.
- R_EXEC: alu_src_a_o=1, alu_src_b_o=00. alu_operation_o per funct: 0x20 ADD, 0x22 SUB, 0x25 OR, 0x00 SLL. Next R_WB.
- R_WB: reg_write_o=1, reg_dst_o=01, mem_to_reg_o=00. Next FETCH.
- I_EXEC: alu_src_a_o=1, alu_src_b_o=10, zero_ext_o=1 only for ORI. alu_operation_o: ADDI ADD, ORI OR, LUI LUI. Next I_WB.
- I_WB: reg_write_o=1, reg_dst_o=00, mem_to_reg_o=00, zero_ext_o held from I_EXEC. Next FETCH.
- BRANCH: alu_src_a_o=1, alu_src_b_o=00, SUB, pc_src_o=01. pc_write_o is Mealy: BEQ gives zero_i, BNE gives ~zero_i. Next FETCH.
- JUMP: pc_src_o=10, pc_write_o=1. JAL additionally sets reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10; the PC write and the $31 write happen in the same cycle, and $31 receives the pre-jump PC+4. Next FETCH.
- Wait counter (8-bit):
  - cleared on entry to FETCH, MEM_RD and MEM_WR; increments each cycle while mem_ready_i=0 in those states.
  - If it reaches MEM_TIMEOUT with mem_ready_i=0: bus_error_o=1 for one cycle, next state FETCH, no IR, PC or memory side effects. In FETCH the same FETCH is reissued.
  - mem_ready_i=1 on the timeout cycle wins: normal completion, no error.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction: immediate return to FETCH with all outputs 0; no partial write strobes after the reset edge.

Test Plan:
- Reset low then release, mem_ready_i=1 constant, IR=ADD (op 0x00, funct 0x20) -> states FETCH, DECODE, R_EXEC, R_WB; alu_operation_o=0011 in R_EXEC; reg_write_o=1, reg_dst_o=01 in R_WB only; 4 cycles per instruction.
- LW with mem_ready_i low for 3 cycles in MEM_RD -> mem_read_o=1, i_or_d_o=1 for 4 cycles, then MEM_WB with mem_to_reg_o=01; total 5 + 3 = 8 cycles.
- BEQ with zero_i=1, then BNE with zero_i=1 -> pc_write_o=1, pc_src_o=01 in BRANCH for BEQ; pc_write_o=0 for BNE; alu_operation_o=0001 in both.
- Opcode 0x3F, then op 0x00 with funct 0x2A -> illegal_o one-cycle pulse in DECODE for each, return to FETCH, no reg_write_o or mem_write_o.
- MEM_TIMEOUT=4, SW with mem_ready_i stuck at 0 -> mem_write_o held 4 cycles, bus_error_o pulses once, next state FETCH; repeat with mem_ready_i=1 on the 4th cycle -> no error.
- JAL, plus reset asserted during MEM_RD of a following LW -> JAL: pc_write_o=1, reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10 in one cycle. Reset: outputs 0 immediately, state FETCH after release.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives the ALU operand/operation selects and reports illegal opcodes and memory timeouts.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       zero_ext_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] alu_operation_o,
  output logic       illegal_o,
  output logic       bus_error_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_I_EXEC   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_OR  = 6'h25;

  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_LUI = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;

  // Counter value on the last permitted wait cycle.
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       illegal;
    logic       bus_error;
  } ctrl_t;

  logic [3:0] state, state_nxt;
  logic [7:0] wait_cnt;
  logic       zext_q;
  ctrl_t      ctrl;

  logic is_lw, is_sw, is_mem, is_r, is_i, is_br, is_jmp, is_ori;
  logic in_wait, timeout;

  assign is_lw  = (opcode_i == OP_LW);
  assign is_sw  = (opcode_i == OP_SW);
  assign is_mem = is_lw || is_sw;
  assign is_r   = (opcode_i == OP_R) &&
                  ((funct_i == FN_ADD) || (funct_i == FN_SUB) ||
                   (funct_i == FN_OR)  || (funct_i == FN_SLL));
  assign is_ori = (opcode_i == OP_ORI);
  assign is_i   = (opcode_i == OP_ADDI) || is_ori || (opcode_i == OP_LUI);
  assign is_br  = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
  assign is_jmp = (opcode_i == OP_J) || (opcode_i == OP_JAL);

  assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready on the final allowed cycle completes normally, so ready masks the timeout.
  assign timeout = in_wait && !mem_ready_i && (wait_cnt >= TO_LAST);

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready_i;
        ctrl.pc_write  = mem_ready_i;
        if (mem_ready_i)  state_nxt = S_DECODE;
        else if (timeout) begin
          ctrl.bus_error = 1'b1;
          state_nxt      = S_FETCH;
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
        if (is_mem)      state_nxt = S_MEM_ADDR;
        else if (is_r)   state_nxt = S_R_EXEC;
        else if (is_i)   state_nxt = S_I_EXEC;
        else if (is_br)  state_nxt = S_BRANCH;
        else if (is_jmp) state_nxt = S_JUMP;
        else begin
          ctrl.illegal = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
        state_nxt      = is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (mem_ready_i) state_nxt = S_MEM_WB;
        else if (timeout) begin
          ctrl.bus_error = 1'b1;
          state_nxt      = S_FETCH;
        end
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b00;
        ctrl.mem_to_reg = 2'b01;
        state_nxt       = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (mem_ready_i) state_nxt = S_FETCH;
        else if (timeout) begin
          ctrl.bus_error = 1'b1;
          state_nxt      = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        case (funct_i)
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLL:  ctrl.alu_op = ALU_SLL;
          default: ctrl.alu_op = ALU_ADD;
        endcase
        state_nxt = S_R_WB;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b01;
        ctrl.mem_to_reg = 2'b00;
        state_nxt       = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.zero_ext  = is_ori;
        case (opcode_i)
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
        state_nxt = S_I_WB;
      end
      S_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 2'b00;
        ctrl.mem_to_reg = 2'b00;
        ctrl.zero_ext   = zext_q;
        state_nxt       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = 2'b01;
        ctrl.pc_write  = (opcode_i == OP_BNE) ? !zero_i : zero_i;
        state_nxt      = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src   = 2'b10;
        ctrl.pc_write = 1'b1;
        // PC still holds PC+4 from fetch, so $31 gets the return address in this same cycle.
        if (opcode_i == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.reg_dst    = 2'b10;
          ctrl.mem_to_reg = 2'b10;
        end
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Cleared whenever a wait state is entered or left, counting only stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     wait_cnt <= '0;
    else if (in_wait && !mem_ready_i && !timeout)   wait_cnt <= wait_cnt + 8'd1;
    else                                            wait_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 zext_q <= 1'b0;
    else if (state == S_I_EXEC) zext_q <= is_ori;
  end

  assign {ir_write_o, pc_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o,
          reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, zero_ext_o, pc_src_o,
          alu_operation_o, illegal_o, bus_error_o} = reset ? ctrl : '0;

endmodule
